// File: rtl/audio_pkg.sv
// Shared constants for the PWM audio player: sample width, silence level
// and PWM counter width.
package audio_pkg;

   localparam int                  SAMPLE_W = 8;
   localparam int                  PWM_BITS = 8;
   localparam logic [SAMPLE_W-1:0] SILENCE  = 8'h80;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with wrapping read/write pointers and an occupancy
// counter. Full/empty/level are derived from the counter alone, so they
// never depend on the current cycle's push or pop requests.
module sample_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = SAMPLE_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_count;

   logic w_push_ok;
   logic w_pop_ok;

   assign o_full    = (r_count == LVL_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_level   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;

   // Storage write; a full FIFO ignores pushes even when a pop is pending.
   // NOTE: the data array has no reset -- stale entries are unreachable
   // because the pointers and count are reset, and leaving it out lets the
   // array map onto plain RAM/flops without a reset tree.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/pwm_audio_player.sv
// PWM audio player: buffers PCM samples in a small FIFO, drains one per
// sample period and plays it as an 8-bit PWM duty cycle. New duty values
// only take effect at a PWM period boundary so the output never glitches.
module pwm_audio_player
   import audio_pkg::*;
#(
   parameter int SAMPLE_DIV = 3146,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic [SAMPLE_W-1:0]           sample_in,
   input  logic                          sample_valid,
   output logic                          sample_ready,
   output logic                          pwm_out,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int DIV_W = 16;

   logic [DIV_W-1:0]    r_div_cnt;
   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic [SAMPLE_W-1:0] r_pending_sample;
   logic [SAMPLE_W-1:0] r_active_sample;
   logic                r_pwm_out;

   logic                w_tick;
   logic                w_wrap;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic [SAMPLE_W-1:0] w_fifo_head;

   assign w_tick       = enable && (r_div_cnt == DIV_W'(SAMPLE_DIV - 1));
   assign w_wrap       = enable && (r_pwm_cnt == '1);
   assign sample_ready = !w_fifo_full;
   assign underrun     = w_tick && w_fifo_empty;
   assign pwm_out      = r_pwm_out;

   sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SAMPLE_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (sample_valid),
      .i_data  (sample_in),
      .i_pop   (w_tick),
      .o_data  (w_fifo_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_level (fifo_level)
   );

   // Sample-rate divider; parked at zero while playback is disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_cnt <= '0;
      end else if (!enable || w_tick) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   // Free-running PWM period counter; parked at zero while disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pwm_cnt <= '0;
      end else if (!enable) begin
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end
   end

   // Pending sample is refreshed every tick; active sample only at a wrap.
   // NOTE: non-blocking assignments make a tick and a wrap on the same edge
   // hand the previous pending value to active_sample, as intended; blocking
   // assignments would let the fresh pop jump straight into the period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending_sample <= SILENCE;
         r_active_sample  <= SILENCE;
      end else begin
         if (w_tick) begin
            r_pending_sample <= w_fifo_empty ? SILENCE : w_fifo_head;
         end
         if (w_wrap) begin
            r_active_sample <= r_pending_sample;
         end
      end
   end

   // Registered comparator output, forced low while disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pwm_out <= 1'b0;
      end else begin
         r_pwm_out <= enable && (r_pwm_cnt < r_active_sample);
      end
   end

endmodule

// File: tb/tb_pwm_audio_player.sv
// Self-checking bench for pwm_audio_player. A behavioural model tracks the
// sample queue, tick times (every SD cycles after enable) and PWM period
// boundaries (every 256 cycles), and predicts per-period high counts,
// FIFO level and underrun pulses.
module tb_pwm_audio_player;

   localparam int          SD    = 600;
   localparam int          DEPTH = 4;
   localparam logic [7:0]  SIL   = 8'h80;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [7:0] sample_in;
   logic       sample_valid;
   logic       sample_ready;
   logic       pwm_out;
   logic       underrun;
   logic [2:0] fifo_level;

   int tests = 0;
   int fails = 0;

   // Behavioural model state.
   logic [7:0] m_q [$];
   logic [7:0] m_pending;
   logic [7:0] m_active;

   // Per-play stimulus schedule and observations.
   int         push_cyc [$];
   logic [7:0] push_dat [$];
   bit         push_all;
   int         exp_duty [$];
   int         win_hi [$];
   int         n_under, n_dut_acc, lvl_err, und_err, duty_err, bad_win;

   pwm_audio_player #(
      .SAMPLE_DIV (SD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .pwm_out      (pwm_out),
      .underrun     (underrun),
      .fifo_level   (fifo_level)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic reset_dut();
      enable       = 1'b0;
      sample_valid = 1'b0;
      sample_in    = 8'h00;
      rst          = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_q.delete();
      m_pending = SIL;
      m_active  = SIL;
      push_cyc.delete();
      push_dat.delete();
      push_all = 1'b0;
   endtask

   // Push one sample while disabled (called at a negedge).
   task automatic preload(input logic [7:0] d);
      sample_valid = 1'b1;
      sample_in    = d;
      if (m_q.size() < DEPTH) m_q.push_back(d);
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   // Enable playback for ncyc cycles starting at the current negedge
   // (cycle 0). Cycle n lies between the n-th and (n+1)-th enabled edges.
   task automatic play(input int ncyc);
      int         hi, pre;
      bit         tk, emp, pv;
      logic [7:0] pd;
      exp_duty.delete();
      win_hi.delete();
      exp_duty.push_back(int'(m_active));
      n_under = 0; n_dut_acc = 0; lvl_err = 0; und_err = 0; duty_err = 0;
      bad_win = -1; hi = 0;
      enable = 1'b1;
      for (int n = 0; n < ncyc; n++) begin
         pre = m_q.size();
         tk  = (n % SD) == SD - 1;
         emp = (pre == 0);
         if (fifo_level !== 3'(pre)) lvl_err++;
         if (sample_ready !== (pre < DEPTH)) lvl_err++;
         if (underrun !== (tk && emp)) und_err++;
         if (underrun === 1'b1) n_under++;
         if (n >= 1) begin
            if (pwm_out === 1'b1) hi++;
            if (n % 256 == 0) begin
               win_hi.push_back(hi);
               hi = 0;
            end
         end
         pv = push_all || (push_cyc.size() > 0 && push_cyc[0] == n);
         pd = 8'h00;
         if (push_all) begin
            pd = 8'($urandom);
         end else if (pv) begin
            pd = push_dat[0];
            void'(push_cyc.pop_front());
            void'(push_dat.pop_front());
         end
         sample_valid = pv;
         sample_in    = pd;
         if (pv && sample_ready === 1'b1) n_dut_acc++;
         // Model of the edge ending cycle n.
         if (n % 256 == 255) begin
            m_active = m_pending;
            exp_duty.push_back(int'(m_active));
         end
         if (tk) begin
            if (emp) m_pending = SIL;
            else     m_pending = m_q.pop_front();
         end
         if (pv && pre < DEPTH) m_q.push_back(pd);
         @(negedge clk);
      end
      sample_valid = 1'b0;
      for (int p = 0; p < win_hi.size(); p++) begin
         if (win_hi[p] != exp_duty[p]) begin
            duty_err++;
            if (bad_win < 0) bad_win = p;
         end
      end
   endtask

   task automatic test_reset();
      logic [7:0] d;
      rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_in = 8'h00;
      #1;
      tests++; if (pwm_out !== 1'b0) begin fails++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
      tests++; if (sample_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", sample_ready); end
      tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
      tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b want 0", underrun); end
      reset_dut();
      preload(8'hF0);
      for (int i = 0; i < 3; i++) begin
         d = 8'($urandom);
         preload(d);
      end
      tests++; if (fifo_level !== 3'd4) begin fails++; $display("FAIL reset_preload_level: got %0d want 4", fifo_level); end
      play(1000);
      tests++; if (lvl_err !== 0 || und_err !== 0 || duty_err !== 0) begin
         fails++; $display("FAIL reset_preplay: level/ready errs %0d underrun errs %0d duty errs %0d (window %0d), want 0", lvl_err, und_err, duty_err, bad_win);
      end
      for (int i = 0; i < 300 && pwm_out !== 1'b1; i++) @(negedge clk);
      tests++; if (pwm_out !== 1'b1) begin fails++; $display("FAIL reset_wait_high: pwm_out %b, want 1 within 300 cycles", pwm_out); end
      #2 rst = 1'b1;
      #1;
      tests++; if (pwm_out !== 1'b0) begin fails++; $display("FAIL async_reset_pwm: got %b want 0", pwm_out); end
      tests++; if (sample_ready !== 1'b1) begin fails++; $display("FAIL async_reset_ready: got %b want 1", sample_ready); end
      tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL async_reset_level: got %0d want 0", fifo_level); end
      @(negedge clk);
      reset_dut();
      play(800);
      tests++; if (win_hi[1] !== 128) begin fails++; $display("FAIL reset_silence_duty: got %0d high cycles want 128", win_hi[1]); end
      tests++; if (duty_err !== 0 || und_err !== 0) begin
         fails++; $display("FAIL reset_silence_trace: duty errs %0d (window %0d) underrun errs %0d, want 0", duty_err, bad_win, und_err);
      end
   endtask

   task automatic test_basic();
      reset_dut();
      preload(8'h40);
      tests++; if (fifo_level !== 3'd1) begin fails++; $display("FAIL basic_level1: got %0d want 1", fifo_level); end
      preload(8'hC0);
      tests++; if (fifo_level !== 3'd2) begin fails++; $display("FAIL basic_level2: got %0d want 2", fifo_level); end
      play(2600);
      tests++; if (win_hi[3] !== 64) begin fails++; $display("FAIL basic_duty_40: got %0d want 64", win_hi[3]); end
      tests++; if (win_hi[5] !== 192) begin fails++; $display("FAIL basic_duty_c0: got %0d want 192", win_hi[5]); end
      tests++; if (lvl_err !== 0) begin fails++; $display("FAIL basic_level_trace: %0d bad cycles want 0", lvl_err); end
      tests++; if (und_err !== 0 || duty_err !== 0) begin
         fails++; $display("FAIL basic_trace: underrun errs %0d duty errs %0d (window %0d), want 0", und_err, duty_err, bad_win);
      end
   endtask

   task automatic test_full();
      int acc;
      reset_dut();
      acc = 0;
      sample_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sample_in = 8'($urandom);
         if (sample_ready === 1'b1) acc++;
         if (m_q.size() < DEPTH) m_q.push_back(sample_in);
         @(negedge clk);
      end
      tests++; if (acc !== 4) begin fails++; $display("FAIL full_accepts: got %0d want 4", acc); end
      tests++; if (sample_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", sample_ready); end
      tests++; if (fifo_level !== 3'd4) begin fails++; $display("FAIL full_level: got %0d want 4", fifo_level); end
      push_all = 1'b1;
      play(610);
      push_all = 1'b0;
      tests++; if (n_dut_acc !== 1) begin fails++; $display("FAIL full_after_tick_accepts: got %0d want 1", n_dut_acc); end
      tests++; if (lvl_err !== 0 || und_err !== 0) begin
         fails++; $display("FAIL full_trace: level/ready errs %0d underrun errs %0d, want 0", lvl_err, und_err);
      end
   endtask

   task automatic test_underrun();
      reset_dut();
      play(1900);
      tests++; if (n_under !== 3) begin fails++; $display("FAIL underrun_count: got %0d pulses want 3", n_under); end
      tests++; if (und_err !== 0) begin fails++; $display("FAIL underrun_timing: %0d bad cycles want 0", und_err); end
      tests++; if (win_hi[6] !== 128 || duty_err !== 0) begin
         fails++; $display("FAIL underrun_duty: window6 %0d want 128, duty errs %0d want 0", win_hi[6], duty_err);
      end
   endtask

   task automatic test_push_at_tick();
      logic [7:0] d;
      reset_dut();
      d = 8'($urandom_range(1, 127));
      push_cyc.push_back(SD - 1);
      push_dat.push_back(d);
      play(1600);
      tests++; if (n_under !== 1 || und_err !== 0) begin
         fails++; $display("FAIL tick_push_underrun: pulses %0d want 1, timing errs %0d want 0", n_under, und_err);
      end
      tests++; if (win_hi[5] !== int'(d)) begin fails++; $display("FAIL tick_push_pop: got %0d high cycles want %0d", win_hi[5], d); end
      tests++; if (lvl_err !== 0 || duty_err !== 0) begin
         fails++; $display("FAIL tick_push_trace: level errs %0d duty errs %0d, want 0", lvl_err, duty_err);
      end
   endtask

   task automatic test_extremes_disable();
      int hi, lerr;
      logic [7:0] d;
      reset_dut();
      preload(8'h00);
      preload(8'hFF);
      play(2000);
      tests++; if (win_hi[3] !== 0) begin fails++; $display("FAIL extreme_00: got %0d high cycles want 0", win_hi[3]); end
      tests++; if (win_hi[5] !== 255) begin fails++; $display("FAIL extreme_ff: got %0d high cycles want 255", win_hi[5]); end
      enable = 1'b0;
      d = 8'($urandom);
      preload(d);
      hi = 0; lerr = 0;
      for (int i = 0; i < 300; i++) begin
         if (pwm_out === 1'b1) hi++;
         if (fifo_level !== 3'(m_q.size())) lerr++;
         @(negedge clk);
      end
      tests++; if (hi !== 0) begin fails++; $display("FAIL disable_pwm: got %0d high cycles want 0", hi); end
      tests++; if (lerr !== 0 || fifo_level !== 3'd1) begin
         fails++; $display("FAIL disable_level: level %0d want 1, bad cycles %0d want 0", fifo_level, lerr);
      end
      play(700);
      tests++; if (win_hi[0] !== 255) begin fails++; $display("FAIL reenable_held_active: got %0d want 255", win_hi[0]); end
      tests++; if (lvl_err !== 0 || und_err !== 0 || duty_err !== 0) begin
         fails++; $display("FAIL reenable_trace: level errs %0d underrun errs %0d duty errs %0d (window %0d), want 0", lvl_err, und_err, duty_err, bad_win);
      end
   endtask

   task automatic test_back_to_back();
      int c;
      reset_dut();
      for (int i = 0; i < DEPTH; i++) preload(8'($urandom));
      c = 50;
      while (c < 3900) begin
         push_cyc.push_back(c);
         push_dat.push_back(8'($urandom));
         c += $urandom_range(150, 450);
      end
      play(4200);
      tests++; if (duty_err !== 0) begin fails++; $display("FAIL b2b_duty: %0d bad windows (first %0d) want 0", duty_err, bad_win); end
      tests++; if (lvl_err !== 0 || und_err !== 0) begin
         fails++; $display("FAIL b2b_trace: level/ready errs %0d underrun errs %0d, want 0", lvl_err, und_err);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_underrun();
      test_push_at_tick();
      test_extremes_disable();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
